lvds_rx_word_align_ctrl: RTL and testbench
==========================================

Name: lvds_rx_word_align_ctrl

Overview:
- Multi-lane word-alignment sequencer for the LVDS receiver.
- Runs after the RX init sequencer has released rx_reset and seen DPA lock.
- Visits each lane in turn. Pulses that lane's bitslip (data-align) input until the parallel word matches the training pattern for MATCH_COUNT consecutive cycles, or until the slip budget runs out.
- Reports per-lane aligned/fail status and a one-cycle done pulse for the link-bringup logic.

Parameters:
- NUM_LANES, 4, number of LVDS RX lanes; must be at least 1.
- DATA_W, 10, deserialisation factor (parallel word width per lane).
- TRAIN_PATTERN, 10'h3F0, expected word when aligned; width DATA_W.
- SETTLE_CYCLES, 4, wait cycles after each bitslip pulse before sampling; must be at least 1.
- MATCH_COUNT, 8, consecutive matching words required to declare a lane aligned; must be at least 1.
- MAX_SLIPS, 10, bitslip pulses allowed per lane before declaring fail; default equals DATA_W.

Ports:
- clk, input, 1, core parallel clock (rx_outclock domain).
- rst_n, input, 1, asynchronous active-high reset. The name follows codebase convention; the polarity is high.
- start, input, 1, begin an alignment pass; sampled only in IDLE.
- rx_data, input, NUM_LANES*DATA_W, parallel words; lane i occupies bits [i*DATA_W +: DATA_W].
- bitslip, output, NUM_LANES, one-cycle slip pulse per lane; at most one bit high at any time.
- aligned, output, NUM_LANES, per-lane sticky aligned flag.
- fail, output, NUM_LANES, per-lane sticky fail flag.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse at the end of a pass.

Behaviour:
- Reset (async, rst_n=1):
  - State goes to IDLE.
  - bitslip=0, aligned=0, fail=0, busy=0, done=0.
  - lane, slip, settle and match counters all go to 0.
  - Reset mid-pass abandons the pass immediately; no done pulse is produced.
- All outputs are registered.
- State machine:
  - IDLE: on start=1, clear aligned/fail, set lane=0, clear counters, go to CHECK. start=0 stays in IDLE. start outside IDLE is ignored.
  - CHECK: compare the selected lane's word to TRAIN_PATTERN every cycle.
    - Match with match_cnt==MATCH_COUNT-1: set aligned[lane], go to NEXT.
    - Match otherwise: match_cnt+1, stay in CHECK.
    - Mismatch with slip_cnt==MAX_SLIPS: set fail[lane], go to NEXT.
    - Mismatch otherwise: match_cnt=0, go to SLIP.
  - SLIP: bitslip[lane]=1 for exactly this cycle; slip_cnt+1; settle_cnt=0; go to SETTLE.
  - SETTLE: settle_cnt+1 per cycle. Data is not sampled here. When settle_cnt==SETTLE_CYCLES-1, clear match_cnt and go to CHECK.
  - NEXT: if lane==NUM_LANES-1, go to DONE. Otherwise lane+1, clear slip/match counters, go to CHECK.
  - DONE: done=1 for one cycle, go to IDLE. aligned/fail hold until the next start or reset.
- Timing:
  - Minimum pass length (every lane already aligned): NUM_LANES*(MATCH_COUNT+1)+1 cycles from the first CHECK cycle to the done cycle inclusive.
  - Each slip costs 1+SETTLE_CYCLES cycles plus the next CHECK cycle.
- Invariants:
  - aligned[i] and fail[i] are never both 1.
  - Counters saturate by construction; no wrap-around.
  - Counter widths use $clog2(param+1).
- Boundary: a mismatch in the middle of a match run while slip budget remains causes a slip; the run is not resumed.

Decomposition:
- Shared package lvds_pkg holds:
  - the state_t enum (IDLE, CHECK, SLIP, SETTLE, NEXT, DONE);
  - default constants LVDS_DATA_W and LVDS_TRAIN_PATTERN, shared with the init sequencer.
- One natural sub-module: lvds_lane_mux, a registered-free NUM_LANES:1 word selector indexed by lane. Everything else stays in the top level.

Test Plan:
- All 4 lanes drive 10'h3F0 continuously, start pulse → no bitslip pulses, aligned=4'b1111, fail=0, done pulse exactly 37 cycles after the first CHECK.
- Lane 2 is rotated by 3 bits and its model rotates back 1 bit per bitslip → exactly 3 bitslip[2] pulses, each followed by at least 4 quiet cycles; aligned=4'b1111.
- Lane 1 drives a constant 10'h000 → 10 bitslip[1] pulses, then fail[1]=1, aligned=4'b1101; the pass still completes lanes 2-3 and pulses done.
- Lane 0 matches 7 cycles, glitches once, then matches → a slip occurs, and aligned[0] sets only after 8 consecutive matches following settle.
- Assert rst_n during SETTLE on lane 3 → all outputs 0 asynchronously, no done pulse; a new start runs a clean pass.
- Pulse start while busy → ignored: lane sequence and done timing are unchanged.

Source files
------------

// File: rtl/lvds_pkg.sv
// Shared LVDS receiver definitions: the alignment FSM state encoding and the
// default deserialisation width / training word used by the RX sequencers.
package lvds_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SLIP   = 3'd2,
        SETTLE = 3'd3,
        NEXT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int                      LVDS_DATA_W        = 10;
    localparam logic [LVDS_DATA_W-1:0]  LVDS_TRAIN_PATTERN = 10'h3F0;

endpackage

// File: rtl/lvds_lane_mux.sv
// Combinational NUM_LANES:1 word selector. An index beyond the last lane
// reads as all-zero so it can never be mistaken for the training word.
module lvds_lane_mux
    import lvds_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = LVDS_DATA_W,
    parameter int LANE_W    = 3
) (
    input  logic [LANE_W-1:0]           lane,
    input  logic [NUM_LANES*DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0]           word
);

    // AND-OR select of the addressed lane's parallel word
    always_comb begin
        word = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            word = word | (rx_data[i*DATA_W +: DATA_W] & {DATA_W{lane == LANE_W'(i)}});
        end
    end

endmodule

// File: rtl/lvds_rx_word_align_ctrl.sv
// Multi-lane word-alignment sequencer. Walks the lanes in order, pulsing each
// lane's bitslip until its parallel word shows the training pattern for
// MATCH_COUNT consecutive cycles or the slip budget is spent, then reports
// sticky per-lane aligned/fail flags and a one-cycle done pulse.
// Note: rst_n is an asynchronous ACTIVE-HIGH reset despite its name.
module lvds_rx_word_align_ctrl
    import lvds_pkg::*;
#(
    parameter int                NUM_LANES     = 4,
    parameter int                DATA_W        = LVDS_DATA_W,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = LVDS_TRAIN_PATTERN,
    parameter int                SETTLE_CYCLES = 4,
    parameter int                MATCH_COUNT   = 8,
    parameter int                MAX_SLIPS     = DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NUM_LANES*DATA_W-1:0] rx_data,
    output logic [NUM_LANES-1:0]        bitslip,
    output logic [NUM_LANES-1:0]        aligned,
    output logic [NUM_LANES-1:0]        fail,
    output logic                        busy,
    output logic                        done
);

    localparam int LANE_W = $clog2(NUM_LANES + 1);
    localparam int MC_W   = $clog2(MATCH_COUNT + 1);
    localparam int SL_W   = $clog2(MAX_SLIPS + 1);
    localparam int ST_W   = $clog2(SETTLE_CYCLES + 1);

    localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 1);
    localparam logic [MC_W-1:0]   MATCH_LAST  = MC_W'(MATCH_COUNT - 1);
    localparam logic [SL_W-1:0]   SLIP_BUDGET = SL_W'(MAX_SLIPS);
    localparam logic [ST_W-1:0]   SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);

    state_t                state_r,      state_nxt_s;
    logic [LANE_W-1:0]     lane_r,       lane_nxt_s;
    logic [SL_W-1:0]       slip_cnt_r,   slip_cnt_nxt_s;
    logic [MC_W-1:0]       match_cnt_r,  match_cnt_nxt_s;
    logic [ST_W-1:0]       settle_cnt_r, settle_cnt_nxt_s;
    logic [NUM_LANES-1:0]  aligned_r,    aligned_nxt_s;
    logic [NUM_LANES-1:0]  fail_r,       fail_nxt_s;
    logic [NUM_LANES-1:0]  bitslip_r,    bitslip_nxt_s;
    logic                  busy_r,       busy_nxt_s;
    logic                  done_r,       done_nxt_s;

    logic [DATA_W-1:0]     word_s;
    logic                  word_match_s;
    logic [NUM_LANES-1:0]  lane_onehot_s;

    lvds_lane_mux #(
        .NUM_LANES (NUM_LANES),
        .DATA_W    (DATA_W),
        .LANE_W    (LANE_W)
    ) u_lane_mux (
        .lane    (lane_r),
        .rx_data (rx_data),
        .word    (word_s)
    );

    assign word_match_s  = (word_s == TRAIN_PATTERN);
    assign lane_onehot_s = NUM_LANES'(1) << lane_r;

    // Next-state, counter and registered-output logic for the alignment walk
    always_comb begin
        state_nxt_s      = state_r;
        lane_nxt_s       = lane_r;
        slip_cnt_nxt_s   = slip_cnt_r;
        match_cnt_nxt_s  = match_cnt_r;
        settle_cnt_nxt_s = settle_cnt_r;
        aligned_nxt_s    = aligned_r;
        fail_nxt_s       = fail_r;
        bitslip_nxt_s    = {NUM_LANES{1'b0}};
        done_nxt_s       = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    aligned_nxt_s    = {NUM_LANES{1'b0}};
                    fail_nxt_s       = {NUM_LANES{1'b0}};
                    lane_nxt_s       = {LANE_W{1'b0}};
                    slip_cnt_nxt_s   = {SL_W{1'b0}};
                    match_cnt_nxt_s  = {MC_W{1'b0}};
                    settle_cnt_nxt_s = {ST_W{1'b0}};
                    state_nxt_s      = CHECK;
                end else begin
                    state_nxt_s      = IDLE;
                end
            end
            CHECK: begin
                if (word_match_s) begin
                    if (match_cnt_r == MATCH_LAST) begin
                        aligned_nxt_s   = aligned_r | lane_onehot_s;
                        state_nxt_s     = NEXT;
                    end else begin
                        match_cnt_nxt_s = match_cnt_r + MC_W'(1);
                    end
                end else begin
                    if (slip_cnt_r == SLIP_BUDGET) begin
                        fail_nxt_s      = fail_r | lane_onehot_s;
                        state_nxt_s     = NEXT;
                    end else begin
                        // A broken run is abandoned, not resumed after the slip
                        match_cnt_nxt_s = {MC_W{1'b0}};
                        bitslip_nxt_s   = lane_onehot_s;
                        state_nxt_s     = SLIP;
                    end
                end
            end
            SLIP: begin
                slip_cnt_nxt_s   = slip_cnt_r + SL_W'(1);
                settle_cnt_nxt_s = {ST_W{1'b0}};
                state_nxt_s      = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    match_cnt_nxt_s  = {MC_W{1'b0}};
                    state_nxt_s      = CHECK;
                end else begin
                    settle_cnt_nxt_s = settle_cnt_r + ST_W'(1);
                end
            end
            NEXT: begin
                if (lane_r == LANE_LAST) begin
                    done_nxt_s      = 1'b1;
                    state_nxt_s     = DONE;
                end else begin
                    lane_nxt_s      = lane_r + LANE_W'(1);
                    slip_cnt_nxt_s  = {SL_W{1'b0}};
                    match_cnt_nxt_s = {MC_W{1'b0}};
                    state_nxt_s     = CHECK;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State, counter and output registers; reset abandons any pass in flight
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r      <= IDLE;
            lane_r       <= {LANE_W{1'b0}};
            slip_cnt_r   <= {SL_W{1'b0}};
            match_cnt_r  <= {MC_W{1'b0}};
            settle_cnt_r <= {ST_W{1'b0}};
            aligned_r    <= {NUM_LANES{1'b0}};
            fail_r       <= {NUM_LANES{1'b0}};
            bitslip_r    <= {NUM_LANES{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            lane_r       <= lane_nxt_s;
            slip_cnt_r   <= slip_cnt_nxt_s;
            match_cnt_r  <= match_cnt_nxt_s;
            settle_cnt_r <= settle_cnt_nxt_s;
            aligned_r    <= aligned_nxt_s;
            fail_r       <= fail_nxt_s;
            bitslip_r    <= bitslip_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign bitslip = bitslip_r;
    assign aligned = aligned_r;
    assign fail    = fail_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_lvds_rx_word_align_ctrl.sv
// Scoreboard bench for the LVDS word-alignment sequencer. Each pass's lane
// behaviour is chosen (directed or $urandom), a reference model derives the
// expected bitslip events, final flags and pass length, and a monitor pops
// and compares them whenever the DUT pulses bitslip or done.
module tb_lvds_rx_word_align_ctrl;

    localparam int NL = 4;
    localparam int DW = 10;
    localparam int SC = 4;
    localparam int MC = 8;
    localparam int MS = 10;
    localparam logic [DW-1:0] TP = 10'h3F0;

    localparam int M_ROT    = 0;   // pattern rotated; each bitslip rotates back one bit
    localparam int M_ZERO   = 1;   // constant zero, never aligns
    localparam int M_GLITCH = 2;   // lane 0 only: one bad word at the 8th check

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [NL*DW-1:0]  rx_data = '0;
    logic [NL-1:0]     bitslip, aligned, fail;
    logic              busy, done;

    always #5 clk = ~clk;

    lvds_rx_word_align_ctrl #(
        .NUM_LANES     (NL),
        .DATA_W        (DW),
        .TRAIN_PATTERN (TP),
        .SETTLE_CYCLES (SC),
        .MATCH_COUNT   (MC),
        .MAX_SLIPS     (MS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rx_data (rx_data),
        .bitslip (bitslip),
        .aligned (aligned),
        .fail    (fail),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        int            kind;   // 0 = bitslip pulse, 1 = done pulse
        int            lane;
        logic [NL-1:0] al;
        logic [NL-1:0] fl;
        int            len;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cfg_mode[NL];
    int  cfg_rot[NL];
    int  rot_s[NL];
    int  bidx = 0;
    int  done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rotr(input logic [DW-1:0] p, input int r);
        logic [2*DW-1:0] d;
        d = {p, p};
        return d[r +: DW];
    endfunction

    // Lane data model: applies bitslip rotations and drives words for next edge
    always @(negedge clk) begin
        if (!busy) begin
            for (int i = 0; i < NL; i++) rot_s[i] = cfg_rot[i];
        end
        for (int i = 0; i < NL; i++) begin
            if (bitslip[i] && cfg_mode[i] == M_ROT) rot_s[i] = (rot_s[i] + DW - 1) % DW;
        end
        for (int i = 0; i < NL; i++) begin
            case (cfg_mode[i])
                M_ZERO:   rx_data[i*DW +: DW] = '0;
                M_GLITCH: rx_data[i*DW +: DW] = (bidx == MC - 1) ? ~TP : TP;
                default:  rx_data[i*DW +: DW] = rotr(TP, rot_s[i]);
            endcase
        end
        if (busy) bidx++;
        else      bidx = 0;
    end

    // Monitor: pops the scoreboard on every bitslip / done pulse
    int   len_cnt = 0;
    int   last_slip = -1000;
    logic busy_q = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        int  idx;
        if (busy && !busy_q) begin
            len_cnt   = 1;
            last_slip = -1000;
        end else if (busy) begin
            len_cnt++;
        end
        busy_q = busy;

        if (bitslip != '0) begin
            idx = -1;
            for (int i = 0; i < NL; i++) if (bitslip[i]) idx = i;
            chk("slip_onehot", $countones(bitslip), 1);
            if (last_slip > -1000) chk("slip_quiet_gap", (len_cnt - last_slip >= SC + 2) ? 1 : 0, 1);
            last_slip = len_cnt;
            if (exp_q.size() == 0) begin
                chk("slip_unexpected", idx, -1);
            end else begin
                e = exp_q.pop_front();
                chk("slip_kind", 0, e.kind);
                chk("slip_lane", idx, e.lane);
            end
        end

        if (done) begin
            done_cnt++;
            chk("excl_aligned_fail", int'(aligned & fail), 0);
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("done_kind", 1, e.kind);
                chk("done_aligned", int'(aligned), int'(e.al));
                chk("done_fail", int'(fail), int'(e.fl));
                chk("done_len", len_cnt, e.len);
            end
        end
    end

    // Reference model: expected events and pass length from lane behaviour
    task automatic push_model();
        ev_t           e;
        int            sum;
        logic [NL-1:0] al, fl;
        sum = 0; al = '0; fl = '0;
        for (int i = 0; i < NL; i++) begin
            int slips;
            case (cfg_mode[i])
                M_ZERO: begin
                    slips = MS;
                    sum  += (MS + 1) + MS * (1 + SC) + 1;
                    fl[i] = 1'b1;
                end
                M_GLITCH: begin
                    slips = 1;
                    sum  += MC + (1 + SC) + MC + 1;
                    al[i] = 1'b1;
                end
                default: begin
                    slips = cfg_rot[i];
                    sum  += slips * (2 + SC) + MC + 1;
                    al[i] = 1'b1;
                end
            endcase
            for (int k = 0; k < slips; k++) begin
                e.kind = 0; e.lane = i; e.al = '0; e.fl = '0; e.len = 0;
                exp_q.push_back(e);
            end
        end
        e.kind = 1; e.lane = -1; e.al = al; e.fl = fl; e.len = sum + 1;
        exp_q.push_back(e);
    endtask

    task automatic set_all_rot0();
        for (int i = 0; i < NL; i++) begin
            cfg_mode[i] = M_ROT;
            cfg_rot[i]  = 0;
        end
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input bit poke, input int bound);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        push_model();
        kick();
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = poke && busy && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        chk("done_seen", int'(seen), 1);
        if (!seen) exp_q.delete();
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_after_done", int'(busy), 0);
        exp_q.delete();
    endtask

    initial begin
        int d0;
        bit seen;
        rst_n = 1'b1;
        start = 1'b0;
        set_all_rot0();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bitslip", int'(bitslip), 0);
        chk("rst_aligned", int'(aligned), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // All lanes already aligned: 37-cycle pass, no slips
        set_all_rot0();
        run_pass(1'b0, 200);

        // Lane 2 rotated by 3 bits
        set_all_rot0();
        cfg_rot[2] = 3;
        run_pass(1'b0, 300);

        // Lane 1 stuck at zero: budget exhausted, remaining lanes still run
        set_all_rot0();
        cfg_mode[1] = M_ZERO;
        run_pass(1'b0, 400);

        // Lane 0 glitches once mid-run
        set_all_rot0();
        cfg_mode[0] = M_GLITCH;
        run_pass(1'b0, 300);

        // Reset while lane 3 is settling after a slip
        set_all_rot0();
        cfg_rot[3] = 3;
        @(negedge clk);
        push_model();
        kick();
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bitslip[3]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reach_lane3_slip", int'(seen), 1);
        repeat (2) @(negedge clk);
        chk("pre_rst_aligned", int'(aligned), 4'b0111);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_bitslip", int'(bitslip), 0);
        chk("mid_rst_aligned", int'(aligned), 0);
        chk("mid_rst_fail", int'(fail), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        exp_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_done_after_rst", done_cnt - d0, 0);
        run_pass(1'b0, 300);

        // Start pulses while busy must not disturb the pass
        for (int i = 0; i < NL; i++) begin
            cfg_mode[i] = M_ROT;
            cfg_rot[i]  = $urandom_range(0, DW - 1);
        end
        run_pass(1'b1, 600);

        // Randomised passes
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < NL; i++) begin
                cfg_mode[i] = ($urandom_range(0, 5) == 0) ? M_ZERO : M_ROT;
                cfg_rot[i]  = $urandom_range(0, DW - 1);
            end
            run_pass(p[0], 600);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
